// File: rtl/block_painter.sv
// Rasterises one row of CELL x CELL square cells onto the 160x120 VGA frame
// buffer, one pixel per clock, with a start/busy/done handshake.
module block_painter #(
    parameter int CELL      = 4,
    parameter int MAX_CELLS = 7,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    input  logic [2:0] width_cells,
    output logic       busy,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot
);

    localparam int DX_W = (MAX_CELLS * CELL > 1) ? $clog2(MAX_CELLS * CELL) : 1;
    localparam int DY_W = (CELL > 1) ? $clog2(CELL) : 1;
    localparam int WC_W = $clog2(MAX_CELLS + 1);

    localparam logic [DY_W-1:0] DY_LAST  = DY_W'(CELL - 1);
    localparam logic [8:0]      SCREEN_W9 = 9'(SCREEN_W);
    localparam logic [7:0]      SCREEN_H8 = 8'(SCREEN_H);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Latched row parameters
    logic [7:0]      bx_reg;
    logic [6:0]      by_reg;
    logic [2:0]      col_reg;
    logic [DX_W-1:0] last_dx_reg, last_dx_next;

    // Scan counters
    logic [DX_W-1:0] dx_reg, dx_next;
    logic [DY_W-1:0] dy_reg, dy_next;

    logic [WC_W-1:0] wc_clamped;
    logic            accept;
    logic [8:0]      sum_x;
    logic [7:0]      sum_y;
    logic            on_screen;

    // Pixel stage between the scan counters and the output registers
    logic [7:0] pix_x_reg;
    logic [6:0] pix_y_reg;
    logic [2:0] pix_col_reg;
    logic       pix_plot_reg;
    logic       pix_done_reg;

    // Output registers
    logic       busy_reg;
    logic       done_reg;
    logic [7:0] vga_x_reg;
    logic [6:0] vga_y_reg;
    logic [2:0] vga_colour_reg;
    logic       plot_reg;

    // Request decode: clamp the width and precompute the last dx of a row.
    always_comb begin
        if (32'(width_cells) > MAX_CELLS) begin
            wc_clamped = WC_W'(MAX_CELLS);
        end else begin
            wc_clamped = WC_W'(width_cells);
        end
        last_dx_next = DX_W'(32'(wc_clamped) * CELL - 1);
        accept       = (state_reg == IDLE) && start;
    end

    // Sums are one bit wider than the screen coordinates so that a carry
    // past 255/127 reads as off-screen instead of wrapping back on-screen.
    always_comb begin
        sum_x     = {1'b0, bx_reg} + 9'(dx_reg);
        sum_y     = {1'b0, by_reg} + 8'(dy_reg);
        on_screen = (sum_x < SCREEN_W9) && (sum_y < SCREEN_H8);
    end

    always_comb begin
        state_next = state_reg;
        dx_next    = dx_reg;
        dy_next    = dy_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    dx_next    = '0;
                    dy_next    = '0;
                    state_next = (wc_clamped == '0) ? DONE : DRAW;
                end
            end
            DRAW: begin
                if (dx_reg == last_dx_reg) begin
                    dx_next = '0;
                    if (dy_reg == DY_LAST) begin
                        dy_next    = '0;
                        state_next = DONE;
                    end else begin
                        dy_next = dy_reg + DY_W'(1);
                    end
                end else begin
                    dx_next = dx_reg + DX_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            dx_reg      <= '0;
            dy_reg      <= '0;
            bx_reg      <= '0;
            by_reg      <= '0;
            col_reg     <= '0;
            last_dx_reg <= '0;
        end else begin
            state_reg <= state_next;
            dx_reg    <= dx_next;
            dy_reg    <= dy_next;
            if (accept) begin
                bx_reg      <= x_in;
                by_reg      <= y_in;
                col_reg     <= colour_in;
                last_dx_reg <= last_dx_next;
            end
        end
    end

    // Coordinates only advance while drawing, so they hold between rows.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_x_reg    <= '0;
            pix_y_reg    <= '0;
            pix_col_reg  <= '0;
            pix_plot_reg <= 1'b0;
            pix_done_reg <= 1'b0;
        end else begin
            if (state_reg == DRAW) begin
                pix_x_reg    <= sum_x[7:0];
                pix_y_reg    <= sum_y[6:0];
                pix_col_reg  <= col_reg;
                pix_plot_reg <= on_screen;
            end else begin
                pix_plot_reg <= 1'b0;
            end
            pix_done_reg <= (state_reg == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            vga_x_reg      <= '0;
            vga_y_reg      <= '0;
            vga_colour_reg <= '0;
            plot_reg       <= 1'b0;
        end else begin
            busy_reg       <= (state_next != IDLE);
            done_reg       <= pix_done_reg;
            vga_x_reg      <= pix_x_reg;
            vga_y_reg      <= pix_y_reg;
            vga_colour_reg <= pix_col_reg;
            plot_reg       <= pix_plot_reg;
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign vga_x      = vga_x_reg;
    assign vga_y      = vga_y_reg;
    assign vga_colour = vga_colour_reg;
    assign plot       = plot_reg;

endmodule

// File: tb/tb_block_painter.sv
// Self-checking bench for block_painter: directed table, corner-case sequences
// and random rows, all compared against a pixel-list reference model.
module tb_block_painter;

    localparam int CELL      = 4;
    localparam int MAX_CELLS = 7;
    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
    logic [2:0] width_cells;
    logic       busy;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;

    int checks   = 0;
    int failures = 0;

    block_painter #(
        .CELL     (CELL),
        .MAX_CELLS(MAX_CELLS),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .width_cells(width_cells),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
    } pix_t;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic [2:0] w;
        int         exp_plots;
    } vec_t;

    pix_t exp_q[$];

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", what, act, req);
        end
    endtask

    // Expected pixel stream: every pixel of the row in scan order.
    task automatic model(input int x, input int y, input int c, input int w);
        int wc;
        pix_t p;
        exp_q.delete();
        wc = (w > MAX_CELLS) ? MAX_CELLS : w;
        for (int dy = 0; dy < CELL; dy++) begin
            for (int dx = 0; dx < wc * CELL; dx++) begin
                p.x = 8'((x + dx) % 256);
                p.y = 7'((y + dy) % 128);
                p.c = 3'(c);
                p.p = ((x + dx) < SCREEN_W) && ((y + dy) < SCREEN_H);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Draw one row from IDLE and check every output cycle against the model.
    task automatic run_row(input int id, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic [2:0] w,
                           input bit mid_start, output int plots);
        int n;
        model(int'(x), int'(y), int'(c), int'(w));
        n = exp_q.size();
        x_in = x; y_in = y; colour_in = c; width_cells = w;
        start = 1'b1;
        tick();
        start       = 1'b0;
        x_in        = 8'($urandom);
        y_in        = 7'($urandom);
        colour_in   = 3'($urandom);
        width_cells = 3'($urandom);
        chk($sformatf("row%0d.k0.busy", id), 32'(busy), 32'd1);
        chk($sformatf("row%0d.k0.plot", id), 32'(plot), 32'd0);
        plots = 0;
        for (int k = 1; k <= n + 2; k++) begin
            if (mid_start) start = (k == 10);
            tick();
            if (plot) plots++;
            if (k >= 2 && k < n + 2) begin
                chk($sformatf("row%0d.k%0d.plot", id, k), 32'(plot), 32'(exp_q[k-2].p));
                chk($sformatf("row%0d.k%0d.x", id, k), 32'(vga_x), 32'(exp_q[k-2].x));
                chk($sformatf("row%0d.k%0d.y", id, k), 32'(vga_y), 32'(exp_q[k-2].y));
                chk($sformatf("row%0d.k%0d.colour", id, k), 32'(vga_colour), 32'(exp_q[k-2].c));
            end else begin
                chk($sformatf("row%0d.k%0d.plot", id, k), 32'(plot), 32'd0);
            end
            chk($sformatf("row%0d.k%0d.done", id, k), 32'(done), 32'(k == n + 2));
            if (k <= n) chk($sformatf("row%0d.k%0d.busy", id, k), 32'(busy), 32'd1);
            else if (k == n + 2) chk($sformatf("row%0d.k%0d.busy", id, k), 32'(busy), 32'd0);
        end
        start = 1'b0;
        $display("row %0d x=%0d y=%0d colour=%0d width=%0d cycles=%0d plots=%0d",
                 id, x, y, c, w, n, plots);
    endtask

    vec_t vecs[6];

    initial begin
        int plots;

        vecs[0] = '{x: 8'd0,   y: 7'd116, c: 3'd5, w: 3'd1, exp_plots: 16};
        vecs[1] = '{x: 8'd156, y: 7'd100, c: 3'd3, w: 3'd3, exp_plots: 16};
        vecs[2] = '{x: 8'd0,   y: 7'd118, c: 3'd6, w: 3'd7, exp_plots: 56};
        vecs[3] = '{x: 8'd10,  y: 7'd10,  c: 3'd2, w: 3'd0, exp_plots: 0};
        vecs[4] = '{x: 8'd252, y: 7'd126, c: 3'd7, w: 3'd2, exp_plots: 0};
        vecs[5] = '{x: 8'd150, y: 7'd116, c: 3'd1, w: 3'd4, exp_plots: 40};

        reset = 1'b0; start = 1'b0;
        x_in = '0; y_in = '0; colour_in = '0; width_cells = '0;
        repeat (3) tick();
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.plot", 32'(plot), 32'd0);
        chk("reset.vga_x", 32'(vga_x), 32'd0);
        chk("reset.vga_y", 32'(vga_y), 32'd0);
        chk("reset.vga_colour", 32'(vga_colour), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_row(i, vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].w, 1'b0, plots);
            chk($sformatf("vec%0d.plot_count", i), 32'(plots), 32'(vecs[i].exp_plots));
        end

        // start pulsed mid-row is ignored and not queued
        run_row(10, 8'd60, 7'd50, 3'd3, 3'd2, 1'b1, plots);
        chk("ignored_start.plot_count", 32'(plots), 32'd32);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (plot || busy) begin
                chk($sformatf("ignored_start.idle%0d.plot_busy", k), {30'd0, plot, busy}, 32'd0);
            end
        end
        chk("ignored_start.final_busy", 32'(busy), 32'd0);

        // Reset asserted on the 10th DRAW cycle
        x_in = 8'd20; y_in = 7'd30; colour_in = 3'd4; width_cells = 3'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        chk("midreset.k9.plot", 32'(plot), 32'd1);
        reset = 1'b0;
        tick();
        chk("midreset.plot", 32'(plot), 32'd0);
        chk("midreset.busy", 32'(busy), 32'd0);
        chk("midreset.done", 32'(done), 32'd0);
        chk("midreset.vga_x", 32'(vga_x), 32'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("midreset.after%0d.plot", k), 32'(plot), 32'd0);
        end
        $display("midreset row aborted on draw cycle 10");
        run_row(11, 8'd20, 7'd30, 3'd4, 3'd2, 1'b0, plots);
        chk("midreset.redraw_count", 32'(plots), 32'd32);

        // Back-to-back erase rows with start held high
        x_in = 8'd40; y_in = 7'd20; colour_in = 3'd0; width_cells = 3'd2;
        start = 1'b1;
        tick();
        plots = 0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (plot) plots++;
            if (k == 34) chk("b2b.k34.done", 32'(done), 32'd1);
            if (k == 35) chk("b2b.k35.plot", 32'(plot), 32'd0);
            if (k == 36) begin
                chk("b2b.k36.plot", 32'(plot), 32'd1);
                chk("b2b.k36.x", 32'(vga_x), 32'd40);
                chk("b2b.k36.y", 32'(vga_y), 32'd20);
                chk("b2b.k36.colour", 32'(vga_colour), 32'd0);
            end
            if (k == 40) start = 1'b0;
            if (k == 68) chk("b2b.k68.done", 32'(done), 32'd1);
        end
        chk("b2b.plot_count", 32'(plots), 32'd64);
        chk("b2b.final_busy", 32'(busy), 32'd0);
        $display("back-to-back erase rows x=40 y=20 plots=%0d", plots);

        // Random rows
        for (int i = 0; i < 20; i++) begin
            run_row(100 + i, 8'($urandom), 7'($urandom), 3'($urandom), 3'($urandom),
                    1'b0, plots);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
